ped_button_conditioner: RTL

Upstream stage of the traffic-light controller. Conditions the raw pedestrian push-button and produces the level request consumed by the controller's button input.
- Synchronizes and debounces the asynchronous pin.
- Converts a press into a latched request that holds until the controller acknowledges it on entering yellow.
- Optionally enforces a post-service lockout counted in 1 s ticks from the pulse generator.

---
 rtl/ped_button_conditioner.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ped_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module : ped_button_conditioner
// Brief  : Synchronizes and debounces the pedestrian button, then latches a
//          request until the controller acks it. Define PED_LOCKOUT_EN to add
//          a post-service lockout counted in 1 Hz ticks.
// Rev    : 1.0  initial release
// ============================================================================
module ped_button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 600000,
  parameter int CNT_W           = 20,
  parameter int LOCKOUT_TICKS   = 30,
  parameter int PRESS_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_raw,
  input  logic               tick,
  input  logic               ack,
  output logic               btn_clean,
  output logic               press_pulse,
  output logic               req,
  output logic               locked,
  output logic [PRESS_W-1:0] press_count
);

  localparam logic [CNT_W-1:0] c_db_last = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef PED_LOCKOUT_EN
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_LOCKOUT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1
  } state_t;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   w_sync_btn;
  logic [CNT_W-1:0]       db_cnt_q, db_cnt_d;
  logic                   clean_q, clean_d;
  logic                   clean_prev_q;
  logic                   pulse_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign w_sync_btn = sync_q[SYNC_STAGES-1];

  // Counter only runs while the synchronized level disagrees with the
  // accepted level, so any glitch back restarts the qualification window.
  always_comb begin
    db_cnt_d = '0;
    clean_d  = clean_q;
    if (w_sync_btn != clean_q) begin
      if (db_cnt_q == c_db_last) begin
        clean_d = w_sync_btn;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt_q     <= '0;
      clean_q      <= 1'b0;
      clean_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      db_cnt_q     <= db_cnt_d;
      clean_q      <= clean_d;
      clean_prev_q <= clean_q;
      pulse_q      <= clean_q & ~clean_prev_q;
    end
  end

  state_t             state_q, state_d;
  logic [PRESS_W-1:0] count_q, count_d;
  logic               req_q;

`ifdef PED_LOCKOUT_EN
  localparam int c_lk_w = (LOCKOUT_TICKS > 1) ? $clog2(LOCKOUT_TICKS) : 1;
  localparam logic [c_lk_w-1:0] c_lk_last = c_lk_w'(LOCKOUT_TICKS - 1);

  logic [c_lk_w-1:0] lk_cnt_q, lk_cnt_d;
  logic              locked_q;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
`ifdef PED_LOCKOUT_EN
    lk_cnt_d = lk_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pulse_q) begin
          state_d = S_PENDING;
          if (count_q != {PRESS_W{1'b1}}) begin
            count_d = count_q + 1'b1;
          end
        end
      end
      // Extra presses while pending merge into the same request.
      S_PENDING: begin
        if (ack) begin
`ifdef PED_LOCKOUT_EN
          state_d = S_LOCKOUT;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef PED_LOCKOUT_EN
      S_LOCKOUT: begin
        if (tick) begin
          if (lk_cnt_q == c_lk_last) begin
            state_d  = S_IDLE;
            lk_cnt_d = '0;
          end else begin
            lk_cnt_d = lk_cnt_q + 1'b1;
          end
        end
      end
`endif
      default: begin
        state_d  = S_IDLE;
`ifdef PED_LOCKOUT_EN
        lk_cnt_d = '0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      req_q    <= 1'b0;
`ifdef PED_LOCKOUT_EN
      lk_cnt_q <= '0;
      locked_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      req_q    <= (state_d == S_PENDING);
`ifdef PED_LOCKOUT_EN
      lk_cnt_q <= lk_cnt_d;
      locked_q <= (state_d == S_LOCKOUT);
`endif
    end
  end

`ifdef PED_LOCKOUT_EN
  assign locked = locked_q;
`else
  localparam int c_unused_lockout_ticks = LOCKOUT_TICKS;
  logic w_unused_tick;
  assign w_unused_tick = tick;
  assign locked        = 1'b0;
`endif

  assign btn_clean   = clean_q;
  assign press_pulse = pulse_q;
  assign req         = req_q;
  assign press_count = count_q;

endmodule
`default_nettype wire
